// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - op encoding, FSM state type and op-to-J/K decode for the JK bank controller
package jk_pkg;

  localparam logic [1:0] OP_HOLD   = 2'd0;
  localparam logic [1:0] OP_RESET  = 2'd1;
  localparam logic [1:0] OP_SET    = 2'd2;
  localparam logic [1:0] OP_TOGGLE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Returns {J, K} for a masked flip-flop under the given op.
  function automatic logic [1:0] op_jk(input logic [1:0] op);
    logic [1:0] jk;
    jk = 2'b00;
    case (op)
      OP_HOLD:   jk = 2'b00;
      OP_RESET:  jk = 2'b01;
      OP_SET:    jk = 2'b10;
      OP_TOGGLE: jk = 2'b11;
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with asynchronous active-high reset
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b00: q <= q;
        2'b01: q <= 1'b0;
        2'b10: q <= 1'b1;
        2'b11: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// rtl/jk_bank_ctrl.sv - command-driven J/K driver for a bank of N JK flip-flops
module jk_bank_ctrl
  import jk_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [N-1:0]  cmd_mask,
  input  logic [CW-1:0] cmd_count,
  output logic [N-1:0]  q,
  output logic          busy,
  output logic          done,
  output logic [7:0]    cmd_total
);

  state_t        state;
  state_t        state_nx;
  logic [1:0]    op_r;
  logic [N-1:0]  mask_r;
  logic [CW-1:0] remaining;
  logic [1:0]    jk;
  logic [N-1:0]  j;
  logic [N-1:0]  k;
  logic          accept;

  assign accept = cmd_valid & cmd_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (cmd_valid) state_nx = (cmd_count == '0) ? ST_DONE : ST_APPLY;
      ST_APPLY: if (remaining == CW'(1)) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // All handshake/status outputs decode state only, so cmd_valid never reaches cmd_ready.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    jk        = 2'b00;
    case (state)
      ST_IDLE:  cmd_ready = 1'b1;
      ST_APPLY: begin
        busy = 1'b1;
        jk   = op_jk(op_r);
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r      <= OP_HOLD;
      mask_r    <= '0;
      remaining <= '0;
      cmd_total <= 8'd0;
    end else begin
      if (accept) begin
        op_r      <= cmd_op;
        mask_r    <= cmd_mask;
        remaining <= cmd_count;
      end else if (state == ST_APPLY) begin
        remaining <= remaining - CW'(1);
      end
      if (state == ST_DONE) cmd_total <= cmd_total + 8'd1;
    end
  end

  // Unmasked bits and every bit outside APPLY see J=K=0 and hold.
  assign j = mask_r & {N{jk[1]}};
  assign k = mask_r & {N{jk[0]}};

  for (genvar i = 0; i < N; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j[i]),
      .k     (k[i]),
      .q     (q[i])
    );
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// tb/tb_jk_bank_ctrl.sv - randomized self-checking bench for jk_bank_ctrl against a command-level model
module tb_jk_bank_ctrl;
  import jk_pkg::*;

  localparam int N  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [N-1:0]  cmd_mask;
  logic [CW-1:0] cmd_count;
  logic [N-1:0]  q;
  logic          busy;
  logic          done;
  logic [7:0]    cmd_total;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] mq;
  logic [7:0]   mtotal;

  jk_bank_ctrl #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_count (cmd_count),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .cmd_total (cmd_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the op on the bank, in plain bit terms.
  function automatic logic [N-1:0] ref_step(input logic [N-1:0] cur, input logic [1:0] op,
                                            input logic [N-1:0] mask);
    logic [N-1:0] nxt;
    nxt = cur;
    for (int b = 0; b < N; b++) begin
      if (mask[b]) begin
        if (op == OP_RESET)       nxt[b] = 1'b0;
        else if (op == OP_SET)    nxt[b] = 1'b1;
        else if (op == OP_TOGGLE) nxt[b] = ~cur[b];
      end
    end
    return nxt;
  endfunction

  task automatic send(input logic [1:0] op, input logic [N-1:0] mask, input logic [CW-1:0] cnt,
                      input bit chain, input logic [1:0] op2, input logic [N-1:0] mask2,
                      input logic [CW-1:0] cnt2);
    int waitc = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_count = cnt;
    while (!cmd_ready && waitc < 64) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (chain) begin
      cmd_op    = op2;
      cmd_mask  = mask2;
      cmd_count = cnt2;
    end else begin
      cmd_valid = 1'b0;
    end
    for (int c = 0; c < int'(cnt); c++) begin
      check("busy_apply", 32'(busy), 32'd1);
      check("done_apply", 32'(done), 32'd0);
      check("ready_apply", 32'(cmd_ready), 32'd0);
      check("q_hold", 32'(q), 32'(mq));
      @(posedge clk); #1;
      mq = ref_step(mq, op, mask);
      check("q_apply", 32'(q), 32'(mq));
    end
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
    check("ready_done", 32'(cmd_ready), 32'd0);
    check("q_done", 32'(q), 32'(mq));
    @(posedge clk); #1;
    mtotal = mtotal + 8'd1;
    check("done_clear", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("ready_back", 32'(cmd_ready), 32'd1);
    check("total", 32'(cmd_total), 32'(mtotal));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_HOLD;
    cmd_mask  = '0;
    cmd_count = '0;
    mq        = '0;
    mtotal    = 8'd0;
    #2;
    check("rst_q", 32'(q), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_total", 32'(cmd_total), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    send(OP_SET, 4'b0101, 4'd1, 1'b0, OP_HOLD, '0, '0);
    check("set_q", 32'(q), 32'b0101);
    send(OP_TOGGLE, 4'b1111, 4'd3, 1'b0, OP_HOLD, '0, '0);
    send(OP_RESET, 4'b1111, 4'd0, 1'b0, OP_HOLD, '0, '0);
    check("zero_cnt_q", 32'(q), 32'b1010);

    // Second command stays presented while the first is still applying.
    send(OP_TOGGLE, 4'b0110, 4'd2, 1'b1, OP_SET, 4'b1000, 4'd1);
    send(OP_SET, 4'b1000, 4'd1, 1'b0, OP_HOLD, '0, '0);

    send(OP_HOLD, 4'b1111, 4'd0, 1'b0, OP_HOLD, '0, '0);
    cmd_valid = 1'b1;
    cmd_op    = OP_TOGGLE;
    cmd_mask  = 4'b0011;
    cmd_count = 4'd10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      mq = ref_step(mq, OP_TOGGLE, 4'b0011);
    end
    check("pre_reset_q", 32'(q), 32'(mq));
    #2 reset = 1'b1;
    #1;
    mq     = '0;
    mtotal = 8'd0;
    check("abort_q", 32'(q), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_total", 32'(cmd_total), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("post_abort_done", 32'(done), 32'd0);
    check("post_abort_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 256; i++) send(OP_RESET, 4'b1111, 4'd0, 1'b0, OP_HOLD, '0, '0);
    check("wrap_total", 32'(cmd_total), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]    rop;
      logic [N-1:0]  rmask;
      logic [CW-1:0] rcnt;
      rop   = 2'($urandom_range(0, 3));
      rmask = N'($urandom);
      rcnt  = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 15)) : CW'($urandom_range(0, 4));
      send(rop, rmask, rcnt, 1'b0, OP_HOLD, '0, '0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check("idle_q", 32'(q), 32'(mq));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
